// File: rtl/debounce_sched_if.sv
// Press-event handshake between the debounce scheduler and the downstream control logic.
interface debounce_sched_if #(
    parameter int N_CH = 4
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic          evt_valid;
    logic [CW-1:0] evt_ch;
    logic          evt_ready;
    logic          evt_drop;

    modport master (
        output evt_valid,
        output evt_ch,
        output evt_drop,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_ch,
        input  evt_drop,
        output evt_ready
    );
endinterface

// File: rtl/debounce_sched.sv
// Multi-channel switch debouncer: one shared sample prescaler, a per-tick sweep over the
// channel FSMs, and a round-robin press-event queue presented over valid/ready.
module debounce_sched #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 8,
    parameter int WAIT_TICKS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_CH-1:0]  sw,
    output logic [N_CH-1:0]  db_level,
    output logic [N_CH-1:0]  db_tick,
    debounce_sched_if.master evt
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int NW = (WAIT_TICKS > 1) ? $clog2(WAIT_TICKS) : 1;

    localparam logic [CW-1:0] LAST_CH  = CW'(N_CH - 1);
    localparam logic [PW-1:0] LAST_PC  = PW'(TICK_DIV - 1);
    localparam logic [NW-1:0] CNT_INIT = NW'(WAIT_TICKS - 1);

    typedef enum logic [1:0] {
        ST_ZERO,
        ST_WAIT1,
        ST_ONE,
        ST_WAIT0
    } ch_state_t;

    logic [N_CH-1:0] sw_m;
    logic [N_CH-1:0] sw_s;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    logic [PW-1:0] pc;
    logic          sample_tick;

    assign sample_tick = (pc == LAST_PC);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= '0;
        end else if (sample_tick) begin
            pc <= '0;
        end else begin
            pc <= pc + PW'(1);
        end
    end

    // One channel per clock after each sample tick; TICK_DIV > N_CH keeps sweeps disjoint.
    logic          sweep_on;
    logic [CW-1:0] idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sweep_on <= 1'b0;
            idx      <= '0;
        end else if (sample_tick) begin
            sweep_on <= 1'b1;
            idx      <= '0;
        end else if (sweep_on) begin
            if (idx == LAST_CH) begin
                sweep_on <= 1'b0;
                idx      <= '0;
            end else begin
                idx <= idx + CW'(1);
            end
        end
    end

    ch_state_t       state_q [N_CH];
    logic [NW-1:0]   cnt_q   [N_CH];
    ch_state_t       cur_state;
    ch_state_t       nxt_state;
    logic [NW-1:0]   cur_cnt;
    logic [NW-1:0]   nxt_cnt;
    logic            cur_s;
    logic            rise;
    logic [N_CH-1:0] rise_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_ZERO;
                cnt_q[i]   <= '0;
            end
        end else if (sweep_on) begin
            state_q[idx] <= nxt_state;
            cnt_q[idx]   <= nxt_cnt;
        end
    end

    // Shared next-state logic, evaluated only for the channel the sweep currently selects.
    always_comb begin
        cur_state = state_q[idx];
        cur_cnt   = cnt_q[idx];
        cur_s     = sw_s[idx];
        nxt_state = cur_state;
        nxt_cnt   = cur_cnt;
        rise      = 1'b0;
        case (cur_state)
            ST_ZERO: begin
                if (cur_s) begin
                    nxt_state = ST_WAIT1;
                    nxt_cnt   = CNT_INIT;
                end
            end
            ST_WAIT1: begin
                if (!cur_s) begin
                    nxt_state = ST_ZERO;
                end else if (cur_cnt == '0) begin
                    nxt_state = ST_ONE;
                    rise      = 1'b1;
                end else begin
                    nxt_cnt = cur_cnt - NW'(1);
                end
            end
            ST_ONE: begin
                if (!cur_s) begin
                    nxt_state = ST_WAIT0;
                    nxt_cnt   = CNT_INIT;
                end
            end
            ST_WAIT0: begin
                if (cur_s) begin
                    nxt_state = ST_ONE;
                end else if (cur_cnt == '0) begin
                    nxt_state = ST_ZERO;
                end else begin
                    nxt_cnt = cur_cnt - NW'(1);
                end
            end
            default: begin
                nxt_state = ST_ZERO;
            end
        endcase
    end

    always_comb begin
        rise_vec = '0;
        if (sweep_on && rise) begin
            rise_vec[idx] = 1'b1;
        end
    end

    logic [N_CH-1:0] level_vec;
    logic [N_CH-1:0] rise_q;

    always_comb begin
        level_vec = '0;
        for (int i = 0; i < N_CH; i++) begin
            level_vec[i] = (state_q[i] == ST_ONE) || (state_q[i] == ST_WAIT0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rise_q   <= '0;
            db_tick  <= '0;
            db_level <= '0;
        end else begin
            rise_q   <= rise_vec;
            db_tick  <= rise_q;
            db_level <= level_vec;
        end
    end

    logic [N_CH-1:0] pend;
    logic [N_CH-1:0] clr_vec;
    logic [N_CH-1:0] pend_nxt;
    logic            drop_nxt;
    logic            accept;
    logic [CW-1:0]   rr;
    logic [CW-1:0]   rr_nxt;
    logic [CW-1:0]   pick_hi;
    logic [CW-1:0]   pick_lo;
    logic            found_hi;
    logic [CW-1:0]   pick_ch;

    assign accept = evt.evt_valid & evt.evt_ready;
    assign rr_nxt = (evt.evt_ch == LAST_CH) ? '0 : evt.evt_ch + CW'(1);

    // A new rise on the channel being accepted re-arms it, so set beats clear without a drop.
    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[evt.evt_ch] = 1'b1;
        end
        pend_nxt = (pend & ~clr_vec) | rise_q;
        drop_nxt = |(rise_q & pend & ~clr_vec);
    end

    always_comb begin
        pick_hi  = '0;
        pick_lo  = '0;
        found_hi = 1'b0;
        for (int j = N_CH - 1; j >= 0; j--) begin
            if (pend[j]) begin
                pick_lo = CW'(j);
                if (CW'(j) >= rr) begin
                    pick_hi  = CW'(j);
                    found_hi = 1'b1;
                end
            end
        end
        pick_ch = found_hi ? pick_hi : pick_lo;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend          <= '0;
            rr            <= '0;
            evt.evt_valid <= 1'b0;
            evt.evt_ch    <= '0;
            evt.evt_drop  <= 1'b0;
        end else begin
            pend         <= pend_nxt;
            evt.evt_drop <= drop_nxt;
            if (accept) begin
                evt.evt_valid <= 1'b0;
                rr            <= rr_nxt;
            end else if (!evt.evt_valid) begin
                evt.evt_valid <= |pend;
                evt.evt_ch    <= pick_ch;
            end
        end
    end
endmodule

// File: tb/tb_debounce_sched.sv
// Directed bench for debounce_sched: reset, debounce timing, chatter rejection,
// round-robin delivery, drop on re-press and the set-beats-clear corner.
module tb_debounce_sched;
    localparam int N_CH       = 4;
    localparam int TICK_DIV   = 8;
    localparam int WAIT_TICKS = 3;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] sw    = 4'h0;
    logic [3:0] db_level;
    logic [3:0] db_tick;

    debounce_sched_if #(.N_CH(N_CH)) evt_bus ();

    debounce_sched #(
        .N_CH      (N_CH),
        .TICK_DIV  (TICK_DIV),
        .WAIT_TICKS(WAIT_TICKS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sw      (sw),
        .db_level(db_level),
        .db_tick (db_tick),
        .evt     (evt_bus)
    );

    always #5 clk = ~clk;

    int cyc;
    int tick_cnt [4];
    int drop_cnt;
    int compared   = 0;
    int mismatched = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Pulse counters sampled on the falling edge, away from DUT updates.
    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                if (db_tick[i]) tick_cnt[i] = tick_cnt[i] + 1;
            end
            if (evt_bus.evt_drop) drop_cnt = drop_cnt + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] sw_v, input logic rdy_v);
        sw                = sw_v;
        evt_bus.evt_ready = rdy_v;
    endtask

    task automatic wait_until(input int target);
        int guard;
        guard = 0;
        while (cyc < target && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc < target) begin
            compared++;
            mismatched++;
            $error("[TB] FAIL wait_cycle: observed %0d expected %0d", cyc, target);
        end
    endtask

    task automatic check_idle(input string tag);
        check_output({tag, "_level"}, 32'(db_level), 32'h0);
        check_output({tag, "_tick"},  32'(db_tick), 32'h0);
        check_output({tag, "_valid"}, 32'(evt_bus.evt_valid), 32'h0);
        check_output({tag, "_ch"},    32'(evt_bus.evt_ch), 32'h0);
        check_output({tag, "_drop"},  32'(evt_bus.evt_drop), 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    int tick_at;
    int base_tick [4];
    int base_drop;
    int seq [8];
    int n_acc;

    initial begin
        drop_cnt = 0;
        for (int i = 0; i < 4; i++) tick_cnt[i] = 0;

        $display("[TB] reset held with all switches high");
        apply_stimulus(4'hF, 1'b0);
        repeat (3) @(negedge clk);
        check_idle("rst_hold");
        reset = 1'b1;
        wait_until(40);
        check_output("rst_rel_level", 32'(db_level), 32'hF);
        for (int i = 0; i < 4; i++) begin
            check_output($sformatf("rst_rel_tick%0d", i), 32'(tick_cnt[i]), 32'd1);
        end
        check_output("rst_rel_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("rst_rel_ch", 32'(evt_bus.evt_ch), 32'h0);

        $display("[TB] accept one event, then reset mid-handshake");
        apply_stimulus(4'hF, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check_output("rr_next_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("rr_next_ch", 32'(evt_bus.evt_ch), 32'h1);
        #2 reset = 1'b0;
        #1 check_idle("rst_async");
        apply_stimulus(4'h0, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] single press on channel 0");
        wait_until(5);
        apply_stimulus(4'h1, 1'b0);
        tick_at = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (db_tick[0]) begin
                tick_at = cyc;
                break;
            end
        end
        check_output("press_tick_cycle", 32'(tick_at), 32'd34);
        check_output("press_tick_vec", 32'(db_tick), 32'h1);
        check_output("press_level", 32'(db_level), 32'h1);
        @(negedge clk);
        check_output("press_tick_clear", 32'(db_tick), 32'h0);
        check_output("press_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("press_ch", 32'(evt_bus.evt_ch), 32'h0);
        apply_stimulus(4'h1, 1'b1);
        @(negedge clk);
        check_output("press_accepted", 32'(evt_bus.evt_valid), 32'h0);
        repeat (3) @(negedge clk);
        check_output("ready_ignored", 32'(evt_bus.evt_valid), 32'h0);
        apply_stimulus(4'h1, 1'b0);

        $display("[TB] chatter on channels 1 and 0");
        wait_until(40);
        for (int i = 0; i < 4; i++) base_tick[i] = tick_cnt[i];
        apply_stimulus(4'h3, 1'b0);
        wait_until(60);
        check_output("glitch_hi_mid", 32'(db_level), 32'h1);
        wait_until(67);
        apply_stimulus(4'h1, 1'b0);
        wait_until(90);
        check_output("glitch_hi_level", 32'(db_level), 32'h1);
        check_output("glitch_hi_tick", 32'(tick_cnt[1] - base_tick[1]), 32'd0);
        check_output("glitch_hi_valid", 32'(evt_bus.evt_valid), 32'h0);
        wait_until(96);
        apply_stimulus(4'h0, 1'b0);
        wait_until(120);
        check_output("glitch_lo_mid", 32'(db_level), 32'h1);
        wait_until(122);
        apply_stimulus(4'h1, 1'b0);
        wait_until(140);
        check_output("glitch_lo_level", 32'(db_level), 32'h1);
        check_output("glitch_lo_tick", 32'(tick_cnt[0] - base_tick[0]), 32'd0);
        check_output("glitch_lo_valid", 32'(evt_bus.evt_valid), 32'h0);

        $display("[TB] all channels rise together, round-robin delivery");
        apply_stimulus(4'h0, 1'b0);
        pulse_reset();
        wait_until(3);
        apply_stimulus(4'hF, 1'b0);
        wait_until(40);
        check_output("rr_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("rr_first_ch", 32'(evt_bus.evt_ch), 32'h0);
        check_output("rr_level", 32'(db_level), 32'hF);
        wait_until(44);
        check_output("rr_ch_locked", 32'(evt_bus.evt_ch), 32'h0);
        apply_stimulus(4'hF, 1'b1);
        n_acc = 0;
        for (int n = 0; n < 12; n++) begin
            if (evt_bus.evt_valid && n_acc < 8) begin
                seq[n_acc] = 32'(evt_bus.evt_ch);
                n_acc++;
            end
            @(negedge clk);
        end
        check_output("rr_accept_count", 32'(n_acc), 32'd4);
        for (int k = 0; k < 4; k++) begin
            check_output($sformatf("rr_order%0d", k), 32'(seq[k]), 32'(k));
        end
        check_output("rr_drained", 32'(evt_bus.evt_valid), 32'h0);
        apply_stimulus(4'hF, 1'b0);

        $display("[TB] channel 2 re-pressed while pending");
        base_drop = drop_cnt;
        for (int i = 0; i < 4; i++) base_tick[i] = tick_cnt[i];
        wait_until(60);
        apply_stimulus(4'hB, 1'b0);
        wait_until(108);
        check_output("drop_released", 32'(db_level), 32'hB);
        apply_stimulus(4'hF, 1'b0);
        wait_until(156);
        check_output("drop_first_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("drop_first_ch", 32'(evt_bus.evt_ch), 32'h2);
        check_output("drop_none_yet", 32'(drop_cnt - base_drop), 32'd0);
        apply_stimulus(4'hB, 1'b0);
        wait_until(204);
        apply_stimulus(4'hF, 1'b0);
        wait_until(252);
        check_output("drop_pulse_count", 32'(drop_cnt - base_drop), 32'd1);
        check_output("drop_tick_count", 32'(tick_cnt[2] - base_tick[2]), 32'd2);
        check_output("drop_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("drop_ch", 32'(evt_bus.evt_ch), 32'h2);
        apply_stimulus(4'hF, 1'b1);
        @(negedge clk);
        apply_stimulus(4'hF, 1'b0);
        repeat (4) @(negedge clk);
        check_output("drop_single_event", 32'(evt_bus.evt_valid), 32'h0);

        $display("[TB] rise on channel 1 in the cycle it is accepted");
        apply_stimulus(4'h0, 1'b0);
        pulse_reset();
        wait_until(3);
        base_drop = drop_cnt;
        for (int i = 0; i < 4; i++) base_tick[i] = tick_cnt[i];
        apply_stimulus(4'h2, 1'b0);
        wait_until(40);
        check_output("same_first_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("same_first_ch", 32'(evt_bus.evt_ch), 32'h1);
        apply_stimulus(4'h0, 1'b0);
        wait_until(80);
        check_output("same_released", 32'(db_level), 32'h0);
        apply_stimulus(4'h2, 1'b0);
        wait_until(114);
        apply_stimulus(4'h2, 1'b1);
        @(negedge clk);
        apply_stimulus(4'h2, 1'b0);
        check_output("same_accept_valid", 32'(evt_bus.evt_valid), 32'h0);
        check_output("same_accept_tick", 32'(db_tick), 32'h2);
        check_output("same_accept_drop", 32'(evt_bus.evt_drop), 32'h0);
        @(negedge clk);
        check_output("same_rearm_valid", 32'(evt_bus.evt_valid), 32'h1);
        check_output("same_rearm_ch", 32'(evt_bus.evt_ch), 32'h1);
        wait_until(120);
        check_output("same_no_drop", 32'(drop_cnt - base_drop), 32'd0);
        check_output("same_tick_count", 32'(tick_cnt[1] - base_tick[1]), 32'd2);
        apply_stimulus(4'h2, 1'b1);
        @(negedge clk);
        apply_stimulus(4'h2, 1'b0);
        repeat (3) @(negedge clk);
        check_output("same_drained", 32'(evt_bus.evt_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
